pc_fetch_ctrl: RTL and testbench

//  Program-counter / fetch-control stage sitting directly downstream of the branch-target LUT.
//  - Holds the 10-bit instruction-memory PC and steps it by +1 each run cycle.
//  - On a taken branch, loads the absolute target returned by the LUT, indexed by the decoder's 4-bit field.
//  - Also provides the Start/Done program handshake and a run-cycle counter for the bench.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_cycle_cnt.sv | 24 ++
 rtl/pc_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default widths for the PC / fetch-control stage.
// Optional feature macro used by this slice: PC_STALL_EN (adds a stall input).
package pc_pkg;

  localparam int PC_W      = 10;
  localparam int IDX_W     = 4;
  localparam int CNT_W_DEF = 16;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam pc_t START_ADDR_DEF = 10'h000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pc_state_t;

  // Sequential fetch step; wraps modulo 2^PC_W with no overflow indication.
  function automatic pc_t pc_inc(input pc_t cur);
    return cur + pc_t'(1);
  endfunction

endpackage

// File: rtl/pc_cycle_cnt.sv
// Saturating run-cycle counter with synchronous clear and count enable.
// Clear wins over enable; once all-ones the value sticks until cleared.
module pc_cycle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count register: clear, else saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control stage behind the branch-target LUT.
// Steps the PC each run cycle, loads the LUT target on a taken branch,
// and provides the start/done program handshake plus a run-cycle counter.
// Optional feature macro: PC_STALL_EN (stall input freezes PC, state and
// cycle counter while running).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | fetching: PC steps by one or loads a taken-branch target
// HALT  | halt instruction reached; PC/counter frozen, done high
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int  CNT_W      = CNT_W_DEF,
  parameter pc_t START_ADDR = START_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] branch_idx,
  input  logic             branch_en,
  input  logic             taken,
  input  logic             halt_req,
`ifdef PC_STALL_EN
  input  logic             stall,
`endif
  output logic [IDX_W-1:0] lut_addr,
  input  logic [PC_W-1:0]  lut_target,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  pc_state_t state, state_nxt;
  pc_t       pc_q, pc_nxt;
  logic      cnt_clr;
  logic      cnt_en;
  logic      run_hold;

  // The LUT is addressed straight from the decoder field; its target feeds
  // the next-PC mux in the same cycle, so no branch delay slot exists.
  assign lut_addr = branch_idx;

`ifdef PC_STALL_EN
  assign run_hold = stall;
`else
  assign run_hold = 1'b0;
`endif

  // State and PC registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= START_ADDR;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // Next-state, next-PC mux and counter control; halt beats branch beats step.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (!run_hold) begin
          cnt_en = 1'b1;
          if (halt_req) begin
            state_nxt = HALT;
          end else if (branch_en && taken) begin
            pc_nxt = lut_target;
          end else begin
            pc_nxt = pc_inc(pc_q);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = START_ADDR;
      end
    endcase
  end

  pc_cycle_cnt #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cycle_cnt)
  );

  assign pc      = pc_q;
  assign running = (state == RUN);
  assign done    = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. A second instance with a 4-bit cycle
// counter shares all inputs to exercise counter saturation.
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [IDX_W-1:0] branch_idx;
  logic             branch_en;
  logic             taken;
  logic             halt_req;
`ifdef PC_STALL_EN
  logic             stall;
`endif
  logic [IDX_W-1:0] lut_addr, lut_addr4;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  pc, pc4;
  logic             running, running4;
  logic             done, done4;
  logic [15:0]      cycle_cnt;
  logic [3:0]       cycle_cnt4;

  logic [PC_W-1:0]  lut_mem [16];

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .branch_idx (branch_idx),
    .branch_en  (branch_en),
    .taken      (taken),
    .halt_req   (halt_req),
`ifdef PC_STALL_EN
    .stall      (stall),
`endif
    .lut_addr   (lut_addr),
    .lut_target (lut_target),
    .pc         (pc),
    .running    (running),
    .done       (done),
    .cycle_cnt  (cycle_cnt)
  );

  pc_fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .branch_idx (branch_idx),
    .branch_en  (branch_en),
    .taken      (taken),
    .halt_req   (halt_req),
`ifdef PC_STALL_EN
    .stall      (stall),
`endif
    .lut_addr   (lut_addr4),
    .lut_target (lut_mem[lut_addr4]),
    .pc         (pc4),
    .running    (running4),
    .done       (done4),
    .cycle_cnt  (cycle_cnt4)
  );

  // Behavioural branch-target LUT addressed by the DUT.
  assign lut_target = lut_mem[lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = PC_W'(i * 32 + 3);
    lut_mem[10] = 10'h00A;
    lut_mem[15] = 10'h3FF;

    rst_n = 1'b0; start = 1'b0; branch_idx = '0;
    branch_en = 1'b0; taken = 1'b0; halt_req = 1'b0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    #2;
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    #10 rst_n = 1'b1;

    // idle ignores branch/halt inputs
    branch_en = 1'b1; taken = 1'b1; halt_req = 1'b1;
    step();
    chk("idle_pc", 32'(pc), 32'h000);
    chk("idle_running", 32'(running), 0);
    branch_en = 1'b0; taken = 1'b0; halt_req = 1'b0;

    // sequential fetch
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_pc", 32'(pc), 32'h000);
    chk("start_running", 32'(running), 1);
    chk("start_cnt", 32'(cycle_cnt), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", 32'(pc), 32'(i));
    end
    chk("seq_cnt", 32'(cycle_cnt), 4);

    // taken branch, then not-taken branch
    branch_idx = 4'hA; branch_en = 1'b1; taken = 1'b1;
    #1 chk("lut_addr", 32'(lut_addr), 32'hA);
    step();
    chk("br_taken_pc", 32'(pc), 32'h00A);
    chk("br_taken_cnt", 32'(cycle_cnt), 5);
    branch_idx = 4'h3; taken = 1'b0;
    step();
    chk("br_not_taken_pc", 32'(pc), 32'h00B);
    branch_en = 1'b0;
    branch_idx = 4'h3; taken = 1'b1;
    step();
    chk("taken_no_en_pc", 32'(pc), 32'h00C);

    // start while running is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_start_pc", 32'(pc), 32'h00D);
    chk("run_start_cnt", 32'(cycle_cnt), 8);

    // wrap: branch to top of memory, then step
    branch_idx = 4'hF; branch_en = 1'b1; taken = 1'b1;
    step();
    chk("br_top_pc", 32'(pc), 32'h3FF);
    branch_en = 1'b0; taken = 1'b0;
    step();
    chk("wrap_pc", 32'(pc), 32'h000);
    chk("wrap_cnt", 32'(cycle_cnt), 10);

    // asynchronous reset mid-run at PC=0x05
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_pc", 32'(pc), 32'h005);
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h000);
    chk("arst_running", 32'(running), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_cnt", 32'(cycle_cnt), 0);
    #2 rst_n = 1'b1;

    // halt has priority over a taken branch
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_halt_pc", 32'(pc), 32'h007);
    halt_req = 1'b1; branch_idx = 4'hA; branch_en = 1'b1; taken = 1'b1;
    step();
    chk("halt_pc", 32'(pc), 32'h007);
    chk("halt_done", 32'(done), 1);
    chk("halt_running", 32'(running), 0);
    chk("halt_cnt", 32'(cycle_cnt), 8);
    halt_req = 1'b0;
    step();
    step();
    chk("halt_frozen_pc", 32'(pc), 32'h007);
    chk("halt_frozen_cnt", 32'(cycle_cnt), 8);
    chk("halt_frozen_done", 32'(done), 1);
    branch_en = 1'b0; taken = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", 32'(pc), 32'h000);
    chk("restart_done", 32'(done), 0);
    chk("restart_running", 32'(running), 1);
    chk("restart_cnt", 32'(cycle_cnt), 0);

    // saturation on the 4-bit counter instance
    for (int i = 0; i < 14; i++) step();
    chk("cnt4_14", 32'(cycle_cnt4), 32'hE);
    for (int i = 0; i < 6; i++) step();
    chk("cnt4_sat", 32'(cycle_cnt4), 32'hF);
    chk("cnt16_20", 32'(cycle_cnt), 20);
    chk("pc_20", 32'(pc), 32'h014);

`ifdef PC_STALL_EN
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_stall_pc", 32'(pc), 32'h002);
    stall = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(pc), 32'h002);
      chk("stall_running", 32'(running), 1);
      chk("stall_cnt", 32'(cycle_cnt), 2);
    end
    stall = 1'b0;
    step();
    chk("unstall_done", 32'(done), 1);
    chk("unstall_pc", 32'(pc), 32'h002);
    halt_req = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
